// File: rtl/telem_pkg.sv
// Shared types, constants and the frame byte layout for the telemetry scheduler.
package telem_pkg;

  localparam logic [7:0] SYNC0       = 8'hAA;
  localparam logic [7:0] SYNC1       = 8'h55;
  localparam int         FRAME_BYTES = 8;
  localparam int         PERIOD_FULL = 4194304;
  localparam int         PERIOD_FAST = 4096;
  // Timer is always sized for the long period so FAST_SIM only changes the wrap point.
  localparam int         TMR_W       = $clog2(PERIOD_FULL);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT
  } telem_state_t;

  // Byte idx of a frame: two sync bytes, then batt/curr/torque as high nibble, low byte.
  function automatic logic [7:0] frame_byte(input logic [2:0]  idx,
                                            input logic [11:0] batt,
                                            input logic [11:0] curr,
                                            input logic [11:0] torque);
    logic [7:0] b;
    case (idx)
      3'd0:    b = SYNC0;
      3'd1:    b = SYNC1;
      3'd2:    b = {4'h0, batt[11:8]};
      3'd3:    b = batt[7:0];
      3'd4:    b = {4'h0, curr[11:8]};
      3'd5:    b = curr[7:0];
      3'd6:    b = {4'h0, torque[11:8]};
      default: b = torque[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/telem_sched_tmr.sv
// Frame period timer: counts 0..PERIOD-1 while enabled, held at zero when disabled.
module telem_period_tmr
  import telem_pkg::*;
#(
  parameter int unsigned PERIOD = PERIOD_FAST,
  parameter int          W      = TMR_W
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam logic [W-1:0] LAST = W'(PERIOD - 1);

  logic [W-1:0] timer;

  assign tick = en && (timer == LAST);

  // Wrap counter; dropping en restarts the period from zero.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      timer <= '0;
    end else if (!en || timer == LAST) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

endmodule

// File: rtl/telem_sched.sv
// Periodic telemetry frame scheduler driving a byte-wide UART transmitter via trmt/tx_done.
module telem_sched #(
  parameter bit          FAST_SIM    = 1'b1,
  parameter int unsigned PERIOD_FULL = telem_pkg::PERIOD_FULL,
  parameter int unsigned PERIOD_FAST = telem_pkg::PERIOD_FAST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [11:0] batt,
  input  logic [11:0] curr,
  input  logic [11:0] torque,
  input  logic        tx_done,
  output logic        trmt,
  output logic [7:0]  tx_data,
  output logic        busy
);

  import telem_pkg::*;

  localparam int unsigned PERIOD = FAST_SIM ? PERIOD_FAST : PERIOD_FULL;

  telem_state_t state, next_state;
  logic [2:0]   idx;
  logic         pending;
  logic         tick;
  logic         start;
  logic         last_byte;
  logic [11:0]  snap_batt, snap_curr, snap_torque;

  telem_period_tmr #(
    .PERIOD (PERIOD),
    .W      (TMR_W)
  ) u_tmr (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  assign last_byte = (idx == 3'(FRAME_BYTES - 1));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and trmt decode; tx_done only matters while waiting on a byte.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    next_state = state;
    trmt       = 1'b0;
    start      = 1'b0;
    unique case (state)
      IDLE: begin
        if ((tick || pending) && en) begin
          start      = 1'b1;
          next_state = SEND;
        end
      end
      SEND: begin
        trmt       = 1'b1;
        next_state = WAIT;
      end
      WAIT: begin
        if (tx_done) begin
          next_state = last_byte ? IDLE : SEND;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Frame datapath: snapshot at start, advance byte index and load tx_data on each tx_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx         <= '0;
      busy        <= 1'b0;
      tx_data     <= 8'h00;
      snap_batt   <= '0;
      snap_curr   <= '0;
      snap_torque <= '0;
    end else if (start) begin
      snap_batt   <= batt;
      snap_curr   <= curr;
      snap_torque <= torque;
      idx         <= '0;
      busy        <= 1'b1;
      tx_data     <= frame_byte(3'd0, batt, curr, torque);
    end else if (state == WAIT && tx_done) begin
      if (last_byte) begin
        busy <= 1'b0;
      end else begin
        idx     <= 3'(idx + 3'd1);
        tx_data <= frame_byte(3'(idx + 3'd1), snap_batt, snap_curr, snap_torque);
      end
    end
  end

  // Overrun flag: one queued frame at most; dropped if telemetry is disabled when it would launch.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
    end else if (start) begin
      pending <= 1'b0;
    end else if (tick && busy) begin
      pending <= 1'b1;
    end else if (state == IDLE && !en) begin
      pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_telem_sched.sv
// Self-checking bench for telem_sched: UART model with configurable tx_done delay and a byte scoreboard.
module tb_telem_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [11:0] batt = 12'hABC;
  logic [11:0] curr = 12'h123;
  logic [11:0] torque = 12'h700;
  logic        tx_done = 1'b0;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        busy;

  always #5 clk = ~clk;

  telem_sched #(.FAST_SIM(1'b1)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .batt    (batt),
    .curr    (curr),
    .torque  (torque),
    .tx_done (tx_done),
    .trmt    (trmt),
    .tx_data (tx_data),
    .busy    (busy)
  );

  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  int         cyc = 0;            // cycles since reset release (cycle 0 = first cycle with rst low)
  int         trmt_cnt = 0;
  int         done_pulses = 0;    // tx_done pulses from the UART model (strays excluded)
  int         last_trmt_cyc = -1;
  int         last_done_cyc = -1;
  int         done_timer = 0;
  int         uart_delay = 5;     // tx_done arrives this many cycles after trmt
  bit         stray = 1'b0;       // inject tx_done in every IDLE cycle and every SEND cycle

  function automatic logic [7:0] model_byte(input int i, input logic [11:0] b,
                                            input logic [11:0] c, input logic [11:0] t);
    case (i)
      0: return 8'hAA;
      1: return 8'h55;
      2: return {4'h0, b[11:8]};
      3: return b[7:0];
      4: return {4'h0, c[11:8]};
      5: return c[7:0];
      6: return {4'h0, t[11:8]};
      default: return t[7:0];
    endcase
  endfunction

  task automatic push_frame();
    for (int i = 0; i < 8; i++) exp_q.push_back(model_byte(i, batt, curr, torque));
  endtask

  // UART model and scoreboard, sampled mid-cycle on the falling edge.
  always @(negedge clk) begin
    logic [7:0] exp_b;
    tx_done = 1'b0;
    if (rst) begin
      done_timer = 0;
      cyc = 0;
    end else begin
      if (done_timer > 0) begin
        done_timer--;
        if (done_timer == 0) begin
          tx_done = 1'b1;
          done_pulses++;
          last_done_cyc = cyc;
          n_tests++;
          if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_in_wait: cycle %0d busy=%b, required 1", cyc, busy);
          end
        end
      end
      if (trmt === 1'b1) begin
        trmt_cnt++;
        last_trmt_cyc = cyc;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_trmt: cycle %0d tx_data=%02h, required no trmt", cyc, tx_data);
        end else begin
          exp_b = exp_q.pop_front();
          if (tx_data !== exp_b) begin
            n_fail++;
            $display("FAIL frame_byte: cycle %0d tx_data=%02h, required %02h", cyc, tx_data, exp_b);
          end
        end
        n_tests++;
        if (busy !== 1'b1) begin
          n_fail++;
          $display("FAIL busy_at_send: cycle %0d busy=%b, required 1", cyc, busy);
        end
        done_timer = uart_delay;
        if (stray) tx_done = 1'b1;
      end else if (stray && busy === 1'b0) begin
        tx_done = 1'b1;
      end
      cyc++;
    end
  end

  task automatic wait_trmt(input int target, input int budget, input string name);
    int n = 0;
    while (trmt_cnt < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (trmt_cnt < target) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: timeout, trmt count %0d, required %0d", name, trmt_cnt, target);
    end
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int n = 0;
    while (done_pulses < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (done_pulses < target) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: timeout, tx_done count %0d, required %0d", name, done_pulses, target);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    stray = 1'b0;
    uart_delay = 5;
    repeat (3) @(posedge clk);
    #1;
    exp_q.delete();
    trmt_cnt = 0;
    done_pulses = 0;
    en = 1'b1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (trmt !== 1'b0) begin n_fail++; $display("FAIL reset_trmt: got %b, required 0", trmt); end
    n_tests++;
    if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %02h, required 00", tx_data); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
  endtask

  task automatic test_basic_frame();
    do_reset();
    push_frame();
    wait_trmt(1, 5000, "basic_first_trmt");
    n_tests++;
    if (last_trmt_cyc !== 4096) begin
      n_fail++;
      $display("FAIL basic_first_trmt_cycle: got %0d, required 4096", last_trmt_cyc);
    end
    wait_done(8, 200, "basic_frame_end");
    // Each byte takes SEND + 5 wait cycles; last tx_done is 5 cycles after the 8th trmt.
    n_tests++;
    if (last_done_cyc !== 4096 + 7 * 6 + 5) begin
      n_fail++;
      $display("FAIL basic_frame_end_cycle: got %0d, required %0d", last_done_cyc, 4096 + 47);
    end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_fall: got %b, required 0", busy); end
    repeat (20) @(posedge clk);
    #1;
    n_tests++;
    if (trmt_cnt !== 8) begin n_fail++; $display("FAIL basic_trmt_count: got %0d, required 8", trmt_cnt); end
    n_tests++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL basic_bytes_left: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_snapshot();
    do_reset();
    push_frame();
    wait_done(3, 6000, "snap_byte2");
    batt = 12'h555;
    push_frame();
    wait_done(16, 6000, "snap_second_frame");
    n_tests++;
    if (last_trmt_cyc !== 8192 + 7 * 6) begin
      n_fail++;
      $display("FAIL snap_second_frame_cycle: got %0d, required %0d", last_trmt_cyc, 8192 + 42);
    end
    n_tests++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL snap_bytes_left: got %0d, required 0", exp_q.size()); end
    batt = 12'hABC;
  endtask

  // Frame of 8 x 1101 cycles spans the ticks at 8191 and 12287: one queued frame, not two.
  task automatic test_overrun();
    do_reset();
    uart_delay = 1100;
    repeat (3) push_frame();
    wait_done(8, 14000, "ovr_frame1");
    uart_delay = 5;
    n_tests++;
    if (last_done_cyc !== 4096 + 7 * 1101 + 1100) begin
      n_fail++;
      $display("FAIL ovr_frame1_end: got %0d, required %0d", last_done_cyc, 12903);
    end
    wait_trmt(9, 10, "ovr_pending_launch");
    // One IDLE cycle (start) separates the final tx_done from the next SEND.
    n_tests++;
    if (last_trmt_cyc !== last_done_cyc + 2) begin
      n_fail++;
      $display("FAIL ovr_pending_send_cycle: got %0d, required %0d", last_trmt_cyc, last_done_cyc + 2);
    end
    wait_done(16, 200, "ovr_frame2");
    // Second frame ends at 12952; a saturated pending leaves nothing until the tick at 16383.
    wait_trmt(17, 5000, "ovr_frame3");
    n_tests++;
    if (last_trmt_cyc !== 16384) begin
      n_fail++;
      $display("FAIL ovr_single_queue: frame 3 at cycle %0d, required 16384", last_trmt_cyc);
    end
    wait_done(24, 200, "ovr_frame3_end");
  endtask

  task automatic test_en_drop();
    int e;
    do_reset();
    push_frame();
    wait_trmt(4, 5000, "en_byte3");
    en = 1'b0;
    wait_done(8, 200, "en_frame_end");
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL en_busy_fall: got %b, required 0", busy); end
    n_tests++;
    if (trmt_cnt !== 8) begin n_fail++; $display("FAIL en_frame_complete: got %0d trmt, required 8", trmt_cnt); end
    repeat (3 * 4096) @(posedge clk);
    #1;
    n_tests++;
    if (trmt_cnt !== 8) begin n_fail++; $display("FAIL en_quiet: got %0d trmt, required 8", trmt_cnt); end
    en = 1'b1;
    e = cyc;
    push_frame();
    wait_trmt(9, 5000, "en_restart");
    n_tests++;
    if (last_trmt_cyc !== e + 4096) begin
      n_fail++;
      $display("FAIL en_restart_cycle: got %0d, required %0d", last_trmt_cyc, e + 4096);
    end
    wait_done(16, 200, "en_restart_end");
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    push_frame();
    wait_trmt(5, 5000, "rst_byte4");
    rst = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (trmt !== 1'b0) begin n_fail++; $display("FAIL rst_mid_trmt: got %b, required 0", trmt); end
    n_tests++;
    if (tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_mid_tx_data: got %02h, required 00", tx_data); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b, required 0", busy); end
    exp_q.delete();
    trmt_cnt = 0;
    done_pulses = 0;
    rst = 1'b0;
    push_frame();
    wait_trmt(1, 5000, "rst_post_frame");
    n_tests++;
    if (last_trmt_cyc !== 4096) begin
      n_fail++;
      $display("FAIL rst_post_frame_cycle: got %0d, required 4096", last_trmt_cyc);
    end
    wait_done(8, 200, "rst_post_frame_end");
  endtask

  task automatic test_stray_done();
    do_reset();
    stray = 1'b1;
    push_frame();
    wait_done(8, 5000, "stray_frame");
    repeat (20) @(posedge clk);
    #1;
    stray = 1'b0;
    n_tests++;
    if (trmt_cnt !== 8) begin n_fail++; $display("FAIL stray_trmt_count: got %0d, required 8", trmt_cnt); end
    n_tests++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL stray_bytes_left: got %0d, required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_snapshot();
    test_overrun();
    test_en_drop();
    test_reset_mid_frame();
    test_stray_done();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #(150000 * 10);
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
